// File: rtl/otter_pkg.sv
// otter_pkg: shared definitions for the OTTER multicycle core.
//   opcode_t    - RV32I major opcodes (ir[6:0]) handled by the sequencer
//   fsm_state_t - control-unit sequencer states
package otter_pkg;

   typedef enum logic [6:0] {
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111,
      JAL    = 7'b1101111,
      JALR   = 7'b1100111,
      BRANCH = 7'b1100011,
      LOAD   = 7'b0000011,
      STORE  = 7'b0100011,
      OP_IMM = 7'b0010011,
      OP     = 7'b0110011,
      SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      WB    = 3'd3,
      INTR  = 3'd4
   } fsm_state_t;

   localparam logic [2:0] F3_PRIV = 3'b000;  // SYSTEM funct3 for MRET/ECALL group

endpackage

// File: rtl/cu_fsm.sv
// cu_fsm: control-unit sequencer for the OTTER multicycle core.
// Steps each instruction through FETCH, EXEC, optional WB (loads) and
// optional INTR entry, gating the decoder's datapath selections.
// Ports:
//   FSM_clk, FSM_rst_n          clock, synchronous active-low reset
//   FSM_opcode, FSM_funct3      ir[6:0], ir[14:12]
//   FSM_intr, FSM_mie           interrupt request, mstatus.MIE
//   FSM_mem_ready               data memory access complete
//   FSM_sysReset .. FSM_mret    datapath enables (combinational)
//   FSM_instret                 retired-instruction count (wraps)
//   FSM_state                   current state, debug only
module cu_fsm
   import otter_pkg::*;
#(
   parameter int unsigned INSTRET_W = 32
) (
   input  logic                 FSM_clk,
   input  logic                 FSM_rst_n,
   input  logic [6:0]           FSM_opcode,
   input  logic [2:0]           FSM_funct3,
   input  logic                 FSM_intr,
   input  logic                 FSM_mie,
   input  logic                 FSM_mem_ready,
   output logic                 FSM_sysReset,
   output logic                 FSM_pcWrite,
   output logic                 FSM_regWrite,
   output logic                 FSM_memRDEN1,
   output logic                 FSM_memRDEN2,
   output logic                 FSM_memWE2,
   output logic                 FSM_csrWE,
   output logic                 FSM_intTaken,
   output logic                 FSM_mret,
   output logic [INSTRET_W-1:0] FSM_instret,
   output logic [2:0]           FSM_state
);

   fsm_state_t           state_q, state_d;
   logic [INSTRET_W-1:0] instret_q, instret_d;
   logic                 complete;

   always_ff @(posedge FSM_clk) begin
      if (!FSM_rst_n) begin
         state_q   <= INIT;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      complete     = 1'b0;
      FSM_sysReset = 1'b0;
      FSM_pcWrite  = 1'b0;
      FSM_regWrite = 1'b0;
      FSM_memRDEN1 = 1'b0;
      FSM_memRDEN2 = 1'b0;
      FSM_memWE2   = 1'b0;
      FSM_csrWE    = 1'b0;
      FSM_intTaken = 1'b0;
      FSM_mret     = 1'b0;

      unique case (state_q)
         INIT: begin
            FSM_sysReset = 1'b1;
            state_d      = FETCH;
         end
         FETCH: begin
            FSM_memRDEN1 = 1'b1;
            state_d      = EXEC;
         end
         EXEC: begin
            case (FSM_opcode)
               LUI, AUIPC, OP_IMM, OP, JAL, JALR: begin
                  FSM_regWrite = 1'b1;
                  FSM_pcWrite  = 1'b1;
                  complete     = 1'b1;
               end
               BRANCH: begin
                  FSM_pcWrite = 1'b1;
                  complete    = 1'b1;
               end
               STORE: begin
                  // Write enable held for the whole stall; PC advances only
                  // in the cycle the memory accepts the store.
                  FSM_memWE2 = 1'b1;
                  if (FSM_mem_ready) begin
                     FSM_pcWrite = 1'b1;
                     complete    = 1'b1;
                  end
               end
               LOAD: begin
                  FSM_memRDEN2 = 1'b1;
                  state_d      = WB;
               end
               SYSTEM: begin
                  FSM_pcWrite = 1'b1;
                  complete    = 1'b1;
                  if (FSM_funct3 == F3_PRIV) begin
                     FSM_mret = 1'b1;
                  end else begin
                     FSM_csrWE    = 1'b1;
                     FSM_regWrite = 1'b1;
                  end
               end
               default: begin
                  // Unknown opcodes retire as NOPs.
                  FSM_pcWrite = 1'b1;
                  complete    = 1'b1;
               end
            endcase
         end
         WB: begin
            FSM_memRDEN2 = 1'b1;
            if (FSM_mem_ready) begin
               FSM_regWrite = 1'b1;
               FSM_pcWrite  = 1'b1;
               complete     = 1'b1;
            end
         end
         INTR: begin
            FSM_pcWrite  = 1'b1;
            FSM_intTaken = 1'b1;
            state_d      = FETCH;
         end
         default: state_d = INIT;
      endcase

      // Interrupts are only considered at an instruction boundary.
      if (complete) begin
         state_d = (FSM_intr && FSM_mie) ? INTR : FETCH;
      end

      // Reset overrides everything, abandoning any pending memory access.
      if (!FSM_rst_n) begin
         state_d      = INIT;
         complete     = 1'b0;
         FSM_sysReset = 1'b1;
         FSM_pcWrite  = 1'b0;
         FSM_regWrite = 1'b0;
         FSM_memRDEN1 = 1'b0;
         FSM_memRDEN2 = 1'b0;
         FSM_memWE2   = 1'b0;
         FSM_csrWE    = 1'b0;
         FSM_intTaken = 1'b0;
         FSM_mret     = 1'b0;
      end
   end

   assign instret_d   = complete ? instret_q + INSTRET_W'(1) : instret_q;
   assign FSM_instret = instret_q;
   assign FSM_state   = state_q;

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm: cycle-by-cycle vector table for cu_fsm plus an instret wrap
// check on a 4-bit counter instance.
module tb_cu_fsm;

   localparam logic [6:0] C_OPIMM = 7'b0010011;
   localparam logic [6:0] C_LOAD  = 7'b0000011;
   localparam logic [6:0] C_STORE = 7'b0100011;
   localparam logic [6:0] C_BR    = 7'b1100011;
   localparam logic [6:0] C_SYS   = 7'b1110011;
   localparam logic [6:0] C_LUI   = 7'b0110111;
   localparam logic [6:0] C_BAD   = 7'b0000000;

   // output bit order: sysReset pcWrite regWrite memRDEN1 memRDEN2 memWE2 csrWE intTaken mret
   localparam logic [8:0] SR  = 9'b100000000;
   localparam logic [8:0] PC  = 9'b010000000;
   localparam logic [8:0] RW  = 9'b001000000;
   localparam logic [8:0] RD1 = 9'b000100000;
   localparam logic [8:0] RD2 = 9'b000010000;
   localparam logic [8:0] WE2 = 9'b000001000;
   localparam logic [8:0] CSR = 9'b000000100;
   localparam logic [8:0] IT  = 9'b000000010;
   localparam logic [8:0] MR  = 9'b000000001;

   typedef struct {
      logic        rst_n;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        intr;
      logic        mie;
      logic        rdy;
      logic [8:0]  outs;
      logic [2:0]  st;
      logic [31:0] ir;
   } vec_t;

   typedef struct {
      int          idx;
      logic [8:0]  outs;
      logic [2:0]  st;
      logic [31:0] ir;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, intr, mie, rdy;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic        sysReset, pcWrite, regWrite, rden1, rden2, we2, csrWE, intTaken, mret;
   logic [31:0] instret;
   logic [2:0]  state;

   logic        w_rst_n;
   logic        w_sr, w_pc, w_rw, w_r1, w_r2, w_we, w_csr, w_it, w_mr;
   logic [3:0]  w_instret;
   logic [2:0]  w_state;

   int n_vec = 0;
   int n_err = 0;
   vec_t tbl[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   cu_fsm #(.INSTRET_W(32)) dut (
      .FSM_clk(clk), .FSM_rst_n(rst_n), .FSM_opcode(op), .FSM_funct3(f3),
      .FSM_intr(intr), .FSM_mie(mie), .FSM_mem_ready(rdy),
      .FSM_sysReset(sysReset), .FSM_pcWrite(pcWrite), .FSM_regWrite(regWrite),
      .FSM_memRDEN1(rden1), .FSM_memRDEN2(rden2), .FSM_memWE2(we2),
      .FSM_csrWE(csrWE), .FSM_intTaken(intTaken), .FSM_mret(mret),
      .FSM_instret(instret), .FSM_state(state)
   );

   cu_fsm #(.INSTRET_W(4)) dut_w (
      .FSM_clk(clk), .FSM_rst_n(w_rst_n), .FSM_opcode(C_LUI), .FSM_funct3(3'b000),
      .FSM_intr(1'b0), .FSM_mie(1'b0), .FSM_mem_ready(1'b1),
      .FSM_sysReset(w_sr), .FSM_pcWrite(w_pc), .FSM_regWrite(w_rw),
      .FSM_memRDEN1(w_r1), .FSM_memRDEN2(w_r2), .FSM_memWE2(w_we),
      .FSM_csrWE(w_csr), .FSM_intTaken(w_it), .FSM_mret(w_mr),
      .FSM_instret(w_instret), .FSM_state(w_state)
   );

   function automatic vec_t v(logic r, logic [6:0] o, logic [2:0] f, logic i, logic m,
                              logic y, logic [8:0] e, logic [2:0] s, logic [31:0] n);
      vec_t t;
      t.rst_n = r; t.op = o; t.f3 = f; t.intr = i; t.mie = m; t.rdy = y;
      t.outs = e; t.st = s; t.ir = n;
      return t;
   endfunction

   task automatic check_w(string name, logic [3:0] exp_ir);
      n_vec++;
      if (w_instret !== exp_ir) begin
         n_err++;
         $display("FAIL %s: instret=%0d expected=%0d", name, w_instret, exp_ir);
      end
   endtask

   initial begin
      exp_t  e;
      logic [8:0] act;

      //            rst op       f3    in  mie rdy expected outs       st  instret
      tbl.push_back(v(0, C_OPIMM, 3'd0, 0, 0, 1, SR,              3'd0, 0)); // in reset
      tbl.push_back(v(1, C_OPIMM, 3'd0, 0, 0, 1, SR,              3'd0, 0)); // INIT
      tbl.push_back(v(1, C_OPIMM, 3'd0, 0, 0, 1, RD1,             3'd1, 0));
      tbl.push_back(v(1, C_OPIMM, 3'd0, 0, 0, 1, PC|RW,           3'd2, 0));
      tbl.push_back(v(1, C_LOAD,  3'd2, 0, 0, 0, RD1,             3'd1, 1));
      tbl.push_back(v(1, C_LOAD,  3'd2, 0, 0, 0, RD2,             3'd2, 1));
      tbl.push_back(v(1, C_LOAD,  3'd2, 0, 0, 0, RD2,             3'd3, 1)); // WB stall 1
      tbl.push_back(v(1, C_LOAD,  3'd2, 0, 0, 0, RD2,             3'd3, 1)); // WB stall 2
      tbl.push_back(v(1, C_LOAD,  3'd2, 0, 0, 1, RD2|PC|RW,       3'd3, 1));
      tbl.push_back(v(1, C_STORE, 3'd2, 0, 0, 0, RD1,             3'd1, 2));
      tbl.push_back(v(1, C_STORE, 3'd2, 0, 0, 0, WE2,             3'd2, 2)); // store stall
      tbl.push_back(v(1, C_STORE, 3'd2, 0, 0, 1, WE2|PC,          3'd2, 2));
      tbl.push_back(v(1, C_BR,    3'd0, 1, 1, 1, RD1,             3'd1, 3)); // intr in FETCH
      tbl.push_back(v(1, C_BR,    3'd0, 1, 1, 1, PC,              3'd2, 3));
      tbl.push_back(v(1, C_BR,    3'd0, 1, 1, 1, PC|IT,           3'd4, 4)); // INTR
      tbl.push_back(v(1, C_BR,    3'd0, 1, 0, 1, RD1,             3'd1, 4));
      tbl.push_back(v(1, C_BR,    3'd0, 1, 0, 1, PC,              3'd2, 4)); // mie=0
      tbl.push_back(v(1, C_SYS,   3'd0, 0, 0, 1, RD1,             3'd1, 5));
      tbl.push_back(v(1, C_SYS,   3'd0, 0, 0, 1, PC|MR,           3'd2, 5));
      tbl.push_back(v(1, C_SYS,   3'd1, 0, 0, 1, RD1,             3'd1, 6));
      tbl.push_back(v(1, C_SYS,   3'd1, 0, 0, 1, PC|CSR|RW,       3'd2, 6));
      tbl.push_back(v(1, C_LOAD,  3'd2, 0, 0, 0, RD1,             3'd1, 7));
      tbl.push_back(v(1, C_LOAD,  3'd2, 0, 0, 0, RD2,             3'd2, 7));
      tbl.push_back(v(1, C_LOAD,  3'd2, 0, 0, 0, RD2,             3'd3, 7)); // stalled WB
      tbl.push_back(v(0, C_LOAD,  3'd2, 0, 0, 1, SR,              3'd3, 7)); // reset in WB
      tbl.push_back(v(1, C_BAD,   3'd0, 0, 0, 1, SR,              3'd0, 0));
      tbl.push_back(v(1, C_BAD,   3'd0, 0, 0, 1, RD1,             3'd1, 0));
      tbl.push_back(v(1, C_BAD,   3'd0, 0, 0, 1, PC,              3'd2, 0)); // NOP opcode
      tbl.push_back(v(1, C_STORE, 3'd2, 0, 0, 1, RD1,             3'd1, 1));
      tbl.push_back(v(1, C_STORE, 3'd2, 1, 1, 0, WE2,             3'd2, 1)); // intr mid-store
      tbl.push_back(v(1, C_STORE, 3'd2, 0, 1, 1, WE2|PC,          3'd2, 1));
      tbl.push_back(v(1, C_OPIMM, 3'd0, 0, 0, 1, RD1,             3'd1, 2)); // no INTR

      rst_n = 1'b0; w_rst_n = 1'b0; op = C_OPIMM; f3 = '0;
      intr = 1'b0; mie = 1'b0; rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         rst_n = tbl[i].rst_n; op = tbl[i].op; f3 = tbl[i].f3;
         intr = tbl[i].intr; mie = tbl[i].mie; rdy = tbl[i].rdy;
         sb.push_back('{i, tbl[i].outs, tbl[i].st, tbl[i].ir});
         @(negedge clk);
         if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard row %0d: queue empty", i);
         end else begin
            e   = sb.pop_front();
            act = {sysReset, pcWrite, regWrite, rden1, rden2, we2, csrWE, intTaken, mret};
            n_vec++;
            if (act !== e.outs || state !== e.st || instret !== e.ir) begin
               n_err++;
               $display("FAIL row %0d: outs=%b state=%0d instret=%0d expected outs=%b state=%0d instret=%0d",
                        e.idx, act, state, instret, e.outs, e.st, e.ir);
            end
         end
         @(posedge clk);
         #1;
      end

      // 4-bit counter: 15 LUIs then a 16th must wrap to 0.
      w_rst_n = 1'b1;
      @(posedge clk); #1;                 // INIT -> FETCH
      repeat (30) @(posedge clk);
      #1;
      check_w("wrap_15", 4'd15);
      repeat (2) @(posedge clk);
      #1;
      check_w("wrap_0", 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cu_fsm.md
# cu_fsm

Control-unit sequencer for the OTTER multicycle core. It steps each instruction through fetch, execute, optional load writeback and interrupt entry. It sits beside the combinational control decoder, takes the same opcode/funct3 fields from the instruction register, and gates the decoder's datapath selections with write/read enables and a system reset. It also owns a retired-instruction counter.

## Interface
Parameters:
- INSTRET_W, 32, width of retired-instruction counter (wraps).

Ports:
- FSM_clk  in  1  core clock; all state changes on rising edge.
- FSM_rst_n  in  1  synchronous, active-low reset.
- FSM_opcode  in  7  ir[6:0] of current instruction.
- FSM_funct3  in  3  ir[14:12].
- FSM_intr  in  1  level interrupt request.
- FSM_mie  in  1  mstatus.MIE; interrupts taken only when 1.
- FSM_mem_ready  in  1  data memory access complete; tie 1 for single-cycle memory.
- FSM_sysReset  out  1  resets PC and register-file pointers.
- FSM_pcWrite  out  1  PC register load enable.
- FSM_regWrite  out  1  register-file write enable.
- FSM_memRDEN1  out  1  instruction memory read enable.
- FSM_memRDEN2  out  1  data memory read enable.
- FSM_memWE2  out  1  data memory write enable.
- FSM_csrWE  out  1  CSR file write enable.
- FSM_intTaken  out  1  interrupt entry: CSR saves mepc, clears MIE.
- FSM_mret  out  1  MRET executing: CSR restores MIE.
- FSM_instret  out  INSTRET_W  retired-instruction count.
- FSM_state  out  3  current state encoding, debug only.

## Operation
- States: INIT, FETCH, EXEC, WB, INTR.
- INIT: sysReset=1, all other enables 0. Next state is FETCH.
- FETCH: memRDEN1=1. Next state is EXEC.
- EXEC outputs, decoded from opcode:
  - LUI, AUIPC, OP-IMM, OP, JAL, JALR: regWrite=1, pcWrite=1; instruction complete.
  - BRANCH: pcWrite=1; complete. The decoder chooses the target.
  - STORE: memWE2=1 while in EXEC. Stay in EXEC until mem_ready=1; in that cycle also pcWrite=1, and the instruction is complete.
  - LOAD: memRDEN2=1, no pcWrite. Next state is WB.
  - SYSTEM (1110011), funct3=000: mret=1, pcWrite=1; complete.
  - SYSTEM, funct3≠000: csrWE=1, regWrite=1, pcWrite=1; complete.
  - Any other opcode: pcWrite=1 only; executes as a NOP, no trap.
- WB: memRDEN2=1. Stay in WB until mem_ready=1; in that cycle regWrite=1, pcWrite=1, and the instruction is complete.
- Completion transition: if FSM_intr && FSM_mie, go to INTR; otherwise go to FETCH. Interrupts are sampled only in the completion cycle and are never taken mid-instruction.
- INTR: pcWrite=1, intTaken=1. Next state is FETCH. INTR does not count as a retired instruction.
- FSM_instret increments by 1 in every completion cycle and wraps modulo 2^INSTRET_W.

## Timing
- Outputs are combinational from the state register plus FSM_opcode, FSM_funct3 and FSM_mem_ready. State and instret are registered.
- Reset: while FSM_rst_n=0, outputs are forced to sysReset=1 with all other enables 0. At the clock edge the state becomes INIT and instret becomes 0. This applies equally to reset asserted mid-instruction, including a pending store or load; the pending access is abandoned.
- After rst_n rises, the sequence is INIT (1 cycle), then FETCH.
- Latency with mem_ready held 1:
  - Non-load instruction: 2 cycles (FETCH, EXEC).
  - Load: 3 cycles (FETCH, EXEC, WB).
  - Interrupt entry: +1 cycle.
- Each cycle mem_ready is low adds one cycle in EXEC (store) or WB (load). memWE2/memRDEN2 are held stable throughout.
- FSM_intr rising in any non-completion cycle has no effect until the next completion cycle.
- At most one enable among memWE2/memRDEN2 is high in any cycle. pcWrite is high for exactly one cycle per instruction and once per INTR.

## Structure
- Shared package otter_pkg holds:
  - opcode_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM).
  - fsm_state_t enum: INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4.
- Keep the block as a single module with the instret counter inline. No sub-module.

## Test plan
- Reset then OP-IMM (0010011), mem_ready=1 → sysReset=1 for the INIT cycle; FETCH memRDEN1=1; EXEC regWrite=pcWrite=1; instret=1 after the EXEC edge.
- LOAD (0000011) with mem_ready low for 2 WB cycles → WB lasts 3 cycles with memRDEN2=1 throughout; regWrite/pcWrite only in the 3rd cycle; total 5 cycles.
- STORE (0100011) with mem_ready low for 1 cycle → memWE2=1 for 2 EXEC cycles; regWrite never asserted; pcWrite only in the 2nd EXEC cycle.
- FSM_intr=1, mie=1 raised during FETCH of BRANCH → EXEC completes; next state INTR with pcWrite=intTaken=1; then FETCH; instret +1 only. Repeat with mie=0 → no INTR.
- SYSTEM funct3=000 → mret=1, pcWrite=1. SYSTEM funct3=001 → csrWE=1, regWrite=1.
- rst_n=0 during a stalled load in WB → next state INIT, instret=0; no regWrite in the reset cycle. Also preset INSTRET_W=4 with 16 completions → counter wraps to 0.
